// File: rtl/ecc_err_log.sv
// ECC error logger: saturating counters, first-error capture, rate-limited irq.
// Define ECC_ERR_LOG_WB_EN to build the one-entry write-back request buffer.
module ecc_err_log #(
    parameter int AW      = 16,
    parameter int SW      = 5,
    parameter int CW      = 16,
    parameter int HOLDOFF = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          chk_vld_i,
    input  logic [AW-1:0] chk_addr_i,
    input  logic [SW-1:0] syndrome_i,
    input  logic          sb_err_i,
    input  logic          db_err_i,
    input  logic          sb_fix_i,
    input  logic          clr_i,
    input  logic [CW-1:0] sb_thresh_i,
    input  logic          irq_ack_i,
    output logic [CW-1:0] sb_cnt_o,
    output logic [CW-1:0] db_cnt_o,
    output logic          sb_cap_vld_o,
    output logic          db_cap_vld_o,
    output logic [AW-1:0] sb_cap_addr_o,
    output logic [AW-1:0] db_cap_addr_o,
    output logic [SW-1:0] sb_cap_syn_o,
    output logic [SW-1:0] db_cap_syn_o,
    output logic          irq_o,
    output logic          wb_req_o,
    output logic [AW-1:0] wb_addr_o,
    input  logic          wb_ack_i,
    output logic          wb_drop_o
);

    // state   | meaning
    // IDLE    | irq low, free to assert on a cause or pending bit
    // ASSERT  | irq high, waiting for acknowledge
    // HOLD    | irq low, hold-off timer running; causes only set pending
    typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_HOLD} irq_state_e;

    irq_state_e  state_q;
    logic [15:0] hold_cnt_q;
    logic        pend_q;
    logic        sb_ev, db_ev, sb_hit, cause;

    // clr_i discards a coincident event completely
    assign db_ev  = chk_vld_i & db_err_i & ~clr_i;
    assign sb_ev  = chk_vld_i & sb_err_i & ~db_err_i & ~clr_i;
    assign sb_hit = sb_ev & ~(&sb_cnt_o) & (sb_thresh_i != '0)
                  & ((sb_cnt_o + CW'(1)) == sb_thresh_i);
    assign cause  = db_ev | sb_hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sb_cnt_o      <= '0;
            db_cnt_o      <= '0;
            sb_cap_vld_o  <= 1'b0;
            db_cap_vld_o  <= 1'b0;
            sb_cap_addr_o <= '0;
            db_cap_addr_o <= '0;
            sb_cap_syn_o  <= '0;
            db_cap_syn_o  <= '0;
        end else if (clr_i) begin
            sb_cnt_o      <= '0;
            db_cnt_o      <= '0;
            sb_cap_vld_o  <= 1'b0;
            db_cap_vld_o  <= 1'b0;
            sb_cap_addr_o <= '0;
            db_cap_addr_o <= '0;
            sb_cap_syn_o  <= '0;
            db_cap_syn_o  <= '0;
        end else begin
            if (sb_ev) begin
                if (!(&sb_cnt_o)) sb_cnt_o <= sb_cnt_o + CW'(1);
                if (!sb_cap_vld_o) begin
                    sb_cap_vld_o  <= 1'b1;
                    sb_cap_addr_o <= chk_addr_i;
                    sb_cap_syn_o  <= syndrome_i;
                end
            end
            if (db_ev) begin
                if (!(&db_cnt_o)) db_cnt_o <= db_cnt_o + CW'(1);
                if (!db_cap_vld_o) begin
                    db_cap_vld_o  <= 1'b1;
                    db_cap_addr_o <= chk_addr_i;
                    db_cap_syn_o  <= syndrome_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            pend_q     <= 1'b0;
            irq_o      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cause || pend_q) begin
                        state_q <= ST_ASSERT;
                        irq_o   <= 1'b1;
                        pend_q  <= 1'b0;
                    end
                end
                ST_ASSERT: begin
                    if (cause) pend_q <= 1'b1;
                    if (irq_ack_i) begin
                        irq_o <= 1'b0;
                        if (HOLDOFF == 0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q    <= ST_HOLD;
                            hold_cnt_q <= 16'(HOLDOFF);
                        end
                    end
                end
                ST_HOLD: begin
                    if (cause) pend_q <= 1'b1;
                    hold_cnt_q <= hold_cnt_q - 16'd1;
                    if (hold_cnt_q == 16'd1) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef ECC_ERR_LOG_WB_EN
    logic wb_load;
    // only information-bit corrections are worth rewriting
    assign wb_load = sb_ev & sb_fix_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_req_o  <= 1'b0;
            wb_addr_o <= '0;
            wb_drop_o <= 1'b0;
        end else begin
            if (wb_load) begin
                if (!wb_req_o || wb_ack_i) begin
                    wb_req_o  <= 1'b1;
                    wb_addr_o <= chk_addr_i;
                end else begin
                    wb_drop_o <= 1'b1;
                end
            end else if (wb_ack_i) begin
                wb_req_o <= 1'b0;
            end
            if (clr_i) wb_drop_o <= 1'b0;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = wb_ack_i ^ sb_fix_i;
    assign wb_req_o  = 1'b0;
    assign wb_addr_o = '0;
    assign wb_drop_o = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_err_log.sv
// Scoreboard bench for ecc_err_log: directed plan sequences plus random traffic
// against a cycle-indexed reference model; works with or without ECC_ERR_LOG_WB_EN.
module tb_ecc_err_log;
    localparam int AW = 16, SW = 5, CW = 4, HOLDOFF = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          chk_vld_i, sb_err_i, db_err_i, sb_fix_i, clr_i, irq_ack_i, wb_ack_i;
    logic [AW-1:0] chk_addr_i;
    logic [SW-1:0] syndrome_i;
    logic [CW-1:0] sb_thresh_i;
    logic [CW-1:0] sb_cnt_o, db_cnt_o;
    logic          sb_cap_vld_o, db_cap_vld_o, irq_o, wb_req_o, wb_drop_o;
    logic [AW-1:0] sb_cap_addr_o, db_cap_addr_o, wb_addr_o;
    logic [SW-1:0] sb_cap_syn_o, db_cap_syn_o;

    ecc_err_log #(.AW(AW), .SW(SW), .CW(CW), .HOLDOFF(HOLDOFF)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .chk_vld_i(chk_vld_i), .chk_addr_i(chk_addr_i),
        .syndrome_i(syndrome_i), .sb_err_i(sb_err_i), .db_err_i(db_err_i),
        .sb_fix_i(sb_fix_i), .clr_i(clr_i), .sb_thresh_i(sb_thresh_i),
        .irq_ack_i(irq_ack_i), .sb_cnt_o(sb_cnt_o), .db_cnt_o(db_cnt_o),
        .sb_cap_vld_o(sb_cap_vld_o), .db_cap_vld_o(db_cap_vld_o),
        .sb_cap_addr_o(sb_cap_addr_o), .db_cap_addr_o(db_cap_addr_o),
        .sb_cap_syn_o(sb_cap_syn_o), .db_cap_syn_o(db_cap_syn_o), .irq_o(irq_o),
        .wb_req_o(wb_req_o), .wb_addr_o(wb_addr_o), .wb_ack_i(wb_ack_i),
        .wb_drop_o(wb_drop_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int sb_cnt, db_cnt, sb_v, db_v, sb_a, db_a, sb_s, db_s;
        int irq, wb_req, wb_addr, wb_drop;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0, n_fail = 0;

    // reference model state
    int   m_sb_cnt, m_db_cnt, m_sb_v, m_db_v, m_sb_a, m_db_a, m_sb_s, m_db_s;
    int   m_irq, m_pend, m_ready_at, m_edge, m_drop;
    int   m_wbq[$];

    function automatic void model_reset();
        m_sb_cnt = 0; m_db_cnt = 0; m_sb_v = 0; m_db_v = 0;
        m_sb_a = 0; m_db_a = 0; m_sb_s = 0; m_db_s = 0;
        m_irq = 0; m_pend = 0; m_ready_at = 0; m_drop = 0;
        m_wbq.delete();
    endfunction

    function automatic void model_step();
        bit c = 0;
        bit load = 0;
        if (clr_i) begin
            m_sb_cnt = 0; m_db_cnt = 0; m_sb_v = 0; m_db_v = 0;
            m_sb_a = 0; m_db_a = 0; m_sb_s = 0; m_db_s = 0; m_drop = 0;
        end else if (chk_vld_i && db_err_i) begin
            if (m_db_cnt < MAXC) m_db_cnt++;
            if (!m_db_v) begin m_db_v = 1; m_db_a = int'(chk_addr_i); m_db_s = int'(syndrome_i); end
            c = 1;
        end else if (chk_vld_i && sb_err_i) begin
            if (m_sb_cnt < MAXC) begin
                m_sb_cnt++;
                if (sb_thresh_i != 0 && m_sb_cnt == int'(sb_thresh_i)) c = 1;
            end
            if (!m_sb_v) begin m_sb_v = 1; m_sb_a = int'(chk_addr_i); m_sb_s = int'(syndrome_i); end
            load = sb_fix_i;
        end
        // irq: after an ack, idle resumes HOLDOFF+1 edges later
        if (m_irq) begin
            if (c) m_pend = 1;
            if (irq_ack_i) begin m_irq = 0; m_ready_at = m_edge + HOLDOFF + 1; end
        end else if (m_edge >= m_ready_at) begin
            if (c || m_pend) begin m_irq = 1; m_pend = 0; end
        end else if (c) begin
            m_pend = 1;
        end
`ifdef ECC_ERR_LOG_WB_EN
        if (wb_ack_i && m_wbq.size() > 0) void'(m_wbq.pop_front());
        if (load) begin
            if (m_wbq.size() == 0) m_wbq.push_back(int'(chk_addr_i));
            else m_drop = 1;
        end
`else
        if (load) m_drop = 0;
`endif
        m_edge++;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.sb_cnt = m_sb_cnt; e.db_cnt = m_db_cnt; e.sb_v = m_sb_v; e.db_v = m_db_v;
        e.sb_a = m_sb_a; e.db_a = m_db_a; e.sb_s = m_sb_s; e.db_s = m_db_s;
        e.irq = m_irq;
`ifdef ECC_ERR_LOG_WB_EN
        e.wb_req = (m_wbq.size() > 0) ? 1 : 0;
        e.wb_addr = (m_wbq.size() > 0) ? m_wbq[0] : -1;
        e.wb_drop = m_drop;
`else
        e.wb_req = 0; e.wb_addr = 0; e.wb_drop = 0;
`endif
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
        end
    endtask

    // monitor: one expected entry per cycle, compared at the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_cnt", int'(sb_cnt_o), e.sb_cnt);
                chk("db_cnt", int'(db_cnt_o), e.db_cnt);
                chk("sb_cap_vld", int'(sb_cap_vld_o), e.sb_v);
                chk("db_cap_vld", int'(db_cap_vld_o), e.db_v);
                chk("sb_cap_addr", int'(sb_cap_addr_o), e.sb_a);
                chk("db_cap_addr", int'(db_cap_addr_o), e.db_a);
                chk("sb_cap_syn", int'(sb_cap_syn_o), e.sb_s);
                chk("db_cap_syn", int'(db_cap_syn_o), e.db_s);
                chk("irq", int'(irq_o), e.irq);
                chk("wb_req", int'(wb_req_o), e.wb_req);
                chk("wb_drop", int'(wb_drop_o), e.wb_drop);
                if (e.wb_addr >= 0) chk("wb_addr", int'(wb_addr_o), e.wb_addr);
            end
        end
    end

    task automatic cyc();
        if (rst_ni) model_step();
        else model_reset();
        exp_q.push_back(model_out());
        @(negedge clk_i);
        #1;
    endtask

    task automatic idle_in();
        chk_vld_i = 0; sb_err_i = 0; db_err_i = 0; sb_fix_i = 0;
        clr_i = 0; irq_ack_i = 0; wb_ack_i = 0;
    endtask

    task automatic ev(input bit sb, input bit db, input bit fix, input int addr, input int syn);
        idle_in();
        chk_vld_i = 1; sb_err_i = sb; db_err_i = db; sb_fix_i = fix;
        chk_addr_i = AW'(addr); syndrome_i = SW'(syn);
        cyc();
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) begin idle_in(); cyc(); end
    endtask

    task automatic ack_cyc();
        idle_in(); irq_ack_i = 1; cyc();
    endtask

    task automatic clr_cyc();
        idle_in(); clr_i = 1; cyc();
    endtask

    initial begin
        rst_ni = 0; idle_in(); chk_addr_i = '0; syndrome_i = '0; sb_thresh_i = '0;
        model_reset(); m_edge = 0;
        cyc(); cyc();
        rst_ni = 1;
        idles(1);

        // three single-bit errors, first captured
        ev(1, 0, 0, 'h10, 'h07); ev(1, 0, 0, 'h20, 'h07); ev(1, 0, 0, 'h30, 'h07);
        idles(2);

        // db saturation and irq one cycle after first event
        clr_cyc();
        for (int i = 0; i < 20; i++) ev(0, 1, 0, 'h100 + i, i);
        ack_cyc(); idles(HOLDOFF + 3);
        ack_cyc(); idles(HOLDOFF + 3);

        // threshold irq, ack, db during hold-off
        clr_cyc();
        sb_thresh_i = CW'(2);
        ev(1, 0, 0, 'h40, 3); ev(1, 0, 0, 'h44, 3);
        idles(1); ack_cyc(); idles(1);
        ev(0, 1, 0, 'h48, 9);
        idles(6); ack_cyc(); idles(HOLDOFF + 2);

        // clear beats a coincident db event
        clr_cyc();
        idle_in(); clr_i = 1; chk_vld_i = 1; db_err_i = 1; chk_addr_i = 'h55; cyc();
        idles(3);

        // write-back: overflow drop, then ack with reload
        sb_thresh_i = '0;
        ev(1, 0, 1, 'hA0, 1); ev(1, 0, 1, 'hB0, 2); idles(1);
        idle_in(); chk_vld_i = 1; sb_err_i = 1; sb_fix_i = 1; wb_ack_i = 1;
        chk_addr_i = 'hC0; cyc();
        idles(1);
        idle_in(); wb_ack_i = 1; cyc();
        ev(1, 0, 0, 'hD0, 4); idles(1);
        clr_cyc(); idles(1);

        // random traffic with a mid-run asynchronous reset
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                rst_ni = 0; idle_in(); cyc(); cyc(); rst_ni = 1;
            end
            if (i % 97 == 0) sb_thresh_i = CW'($urandom_range(0, 6));
            chk_vld_i  = ($urandom_range(0, 3) != 0);
            sb_err_i   = $urandom_range(0, 1);
            db_err_i   = ($urandom_range(0, 5) == 0);
            sb_fix_i   = $urandom_range(0, 1);
            clr_i      = ($urandom_range(0, 40) == 0);
            irq_ack_i  = ($urandom_range(0, 3) == 0);
            wb_ack_i   = ($urandom_range(0, 2) == 0);
            chk_addr_i = AW'($urandom);
            syndrome_i = SW'($urandom);
            cyc();
        end
        idles(2);
        if (exp_q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
